// File: rtl/key_pkg.sv
// key_pkg: shared key-bank constants, key index names and one-hot encoder
package key_pkg;
  localparam int KEY_W  = 8;
  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] KEY_0 = 3'd0;
  localparam logic [CODE_W-1:0] KEY_1 = 3'd1;
  localparam logic [CODE_W-1:0] KEY_2 = 3'd2;
  localparam logic [CODE_W-1:0] KEY_3 = 3'd3;
  localparam logic [CODE_W-1:0] KEY_4 = 3'd4;
  localparam logic [CODE_W-1:0] KEY_5 = 3'd5;
  localparam logic [CODE_W-1:0] KEY_6 = 3'd6;
  localparam logic [CODE_W-1:0] KEY_7 = 3'd7;
  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } key_hit_t;
  // valid only when exactly one bit is set; code is that bit's index
  function automatic key_hit_t onehot_to_code(input logic [KEY_W-1:0] k);
    key_hit_t r;
    r.valid = (k != '0) && ((k & (k - KEY_W'(1))) == '0);
    r.code  = '0;
    for (int i = 0; i < KEY_W; i++)
      if (k[i]) r.code = CODE_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: one-hot hit decode plus edge stage giving one push per press
module key_press_detect #(
  parameter int KEY_W  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key,
  output logic              push,
  output logic [CODE_W-1:0] code_q
);
  import key_pkg::*;
  key_hit_t          h;
  logic              hit_d, hit_q, hit_dly_d, hit_dly_q;
  logic [CODE_W-1:0] code_d;
  assign h    = onehot_to_code(key);
  assign push = hit_q & ~hit_dly_q;
  // next state of the hit pipeline; a key-to-key change keeps hit high so no new push
  always_comb begin
    hit_d     = h.valid;
    code_d    = h.code;
    hit_dly_d = hit_q;
  end
  // hit pipeline registers; hit_dly clears on reset so a held key re-fires once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q     <= 1'b0;
      hit_dly_q <= 1'b0;
      code_q    <= '0;
    end else begin
      hit_q     <= hit_d;
      hit_dly_q <= hit_dly_d;
      code_q    <= code_d;
    end
  end
endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: queues encoded key presses for a valid/ready consumer
module key_event_fifo #(
  parameter int KEY_W  = 8,
  parameter int CODE_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic [CODE_W-1:0] count,
  output logic              overflow
);
  import key_pkg::*;
  localparam int PW = $clog2(DEPTH);
  logic              push, pop, full, wr_en, drop;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CODE_W-1:0] count_d, count_q;
  logic              valid_d, valid_q, ovf_d, ovf_q;
  key_press_detect #(.KEY_W(KEY_W), .CODE_W(CODE_W)) u_det (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .push   (push),
    .code_q (code_q)
  );
  assign evt_valid = valid_q;
  assign evt_code  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = ovf_q;
  // a push into a full FIFO survives only if a pop frees the slot that same cycle
  always_comb begin
    pop      = valid_q & evt_ready;
    full     = count_q == CODE_W'(DEPTH);
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CODE_W'(wr_en) - CODE_W'(pop);
    valid_d  = count_d != '0;
    ovf_d    = drop | (ovf_q & ~clr_ovf);
  end
  // pointer, occupancy and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end
  // entry storage; contents after reset are irrelevant since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= code_q;
  end
endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: directed scenarios plus randomized run against a queue model
module tb_key_event_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key = 8'h00;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] count;
  logic       overflow;
  int pass_cnt = 0;
  int total = 0;
  key_event_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .count     (count),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  int mq[$];
  bit m_ovf, h1, h2, m_push, m_pop, m_drop;
  int c1;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 0; h1 = 0; h2 = 0; c1 = 0;
    end else begin
      m_push = h1 && !h2;
      m_pop  = (mq.size() > 0) && evt_ready;
      m_drop = m_push && (mq.size() == 4) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_drop) mq.push_back(c1);
      m_ovf = m_drop || (m_ovf && !clr_ovf);
      h2 = h1;
      h1 = ($countones(key) == 1);
      c1 = $clog2(key);
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask
  task automatic press(input logic [7:0] k);
    key = k; cyc(1); key = 8'h00; cyc(1);
  endtask
  task automatic drain();
    key = 8'h00; cyc(2); evt_ready = 1'b1; cyc(5); evt_ready = 1'b0; clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0; cyc(2);
    total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", evt_valid); else pass_cnt++;
    total++; if (evt_code !== 3'd0) $display("FAIL reset_code got %0d want 0", evt_code); else pass_cnt++;
    total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0d want 0", overflow); else pass_cnt++;
    rst = 1'b1; cyc(1);
  endtask
  task automatic test_single_press();
    key = 8'h08; cyc(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL t1_early_valid got %0d want 0", evt_valid); else pass_cnt++;
    cyc(1);
    total++; if (evt_valid !== 1'b1) $display("FAIL t1_valid got %0d want 1", evt_valid); else pass_cnt++;
    total++; if (evt_code !== 3'd3) $display("FAIL t1_code got %0d want 3", evt_code); else pass_cnt++;
    cyc(8); key = 8'h00; cyc(3);
    total++; if (count !== 3'd1) $display("FAIL t1_count got %0d want 1", count); else pass_cnt++;
    drain();
  endtask
  task automatic test_overflow();
    press(8'h01); press(8'h02); press(8'h04); press(8'h08); press(8'h10); cyc(1);
    total++; if (count !== 3'd4) $display("FAIL t2_count got %0d want 4", count); else pass_cnt++;
    total++; if (overflow !== 1'b1) $display("FAIL t2_ovf got %0d want 1", overflow); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++; if (evt_code !== 3'(i)) $display("FAIL t2_pop_code got %0d want %0d", evt_code, i); else pass_cnt++;
      evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    end
    total++; if (evt_valid !== 1'b0) $display("FAIL t2_empty_valid got %0d want 0", evt_valid); else pass_cnt++;
    total++; if (evt_code !== 3'd0) $display("FAIL t2_empty_code got %0d want 0", evt_code); else pass_cnt++;
    drain();
  endtask
  task automatic test_full_pushpop();
    logic [2:0] exp [4];
    exp[0] = 3'd1; exp[1] = 3'd2; exp[2] = 3'd3; exp[3] = 3'd7;
    press(8'h01); press(8'h02); press(8'h04); press(8'h08);
    key = 8'h80; cyc(1); key = 8'h00; evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    total++; if (count !== 3'd4) $display("FAIL t3_count got %0d want 4", count); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL t3_ovf got %0d want 0", overflow); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++; if (evt_code !== exp[i]) $display("FAIL t3_pop_code got %0d want %0d", evt_code, exp[i]); else pass_cnt++;
      evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    end
    drain();
  endtask
  task automatic test_invalid();
    key = 8'h11; cyc(3); key = 8'h00; cyc(3);
    total++; if (count !== 3'd0) $display("FAIL t4_multi_count got %0d want 0", count); else pass_cnt++;
    key = 8'h40; cyc(2); key = 8'h20; cyc(3); key = 8'h00; cyc(2);
    total++; if (count !== 3'd1) $display("FAIL t4_change_count got %0d want 1", count); else pass_cnt++;
    total++; if (evt_code !== 3'd6) $display("FAIL t4_change_code got %0d want 6", evt_code); else pass_cnt++;
    drain();
  endtask
  task automatic test_async_reset();
    press(8'h01); press(8'h04); key = 8'h02; cyc(3);
    total++; if (count !== 3'd3) $display("FAIL t5_pre_count got %0d want 3", count); else pass_cnt++;
    #2 rst = 1'b0; #1;
    total++; if (count !== 3'd0) $display("FAIL t5_rst_count got %0d want 0", count); else pass_cnt++;
    total++; if (evt_valid !== 1'b0) $display("FAIL t5_rst_valid got %0d want 0", evt_valid); else pass_cnt++;
    @(negedge clk); rst = 1'b1; cyc(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL t5_early_valid got %0d want 0", evt_valid); else pass_cnt++;
    cyc(1);
    total++; if (evt_valid !== 1'b1) $display("FAIL t5_valid got %0d want 1", evt_valid); else pass_cnt++;
    total++; if (evt_code !== 3'd1) $display("FAIL t5_code got %0d want 1", evt_code); else pass_cnt++;
    cyc(2);
    total++; if (count !== 3'd1) $display("FAIL t5_count got %0d want 1", count); else pass_cnt++;
    drain();
  endtask
  task automatic test_drop_clr();
    press(8'h01); press(8'h02); press(8'h04); press(8'h08);
    key = 8'h10; cyc(1); key = 8'h00; clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL t6_set_wins got %0d want 1", overflow); else pass_cnt++;
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL t6_clr got %0d want 0", overflow); else pass_cnt++;
    drain();
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0, 1: key = 8'h00;
          2: key = 8'h01 << $urandom_range(7);
          default: key = 8'($urandom);
        endcase
      end
      evt_ready = ($urandom_range(3) == 0);
      clr_ovf = ($urandom_range(15) == 0);
      cyc(1);
      total++; if (count !== 3'(mq.size())) $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); else pass_cnt++;
      total++; if (evt_valid !== (mq.size() != 0)) $display("FAIL rnd_valid cyc %0d got %0d want %0d", i, evt_valid, mq.size() != 0); else pass_cnt++;
      total++; if (evt_code !== (mq.size() != 0 ? 3'(mq[0]) : 3'd0)) $display("FAIL rnd_code cyc %0d got %0d want %0d", i, evt_code, mq.size() != 0 ? mq[0] : 0); else pass_cnt++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %0d want %0d", i, overflow, m_ovf); else pass_cnt++;
    end
    evt_ready = 1'b0; clr_ovf = 1'b0;
    drain();
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single_press();
    test_overflow();
    test_full_pushpop();
    test_invalid();
    test_async_reset();
    test_drop_clr();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/key_event_fifo.md
# key_event_fifo

Captures single-key presses from the 8-bit one-hot key bank, encodes each new press into a 3-bit key code, and queues the codes in a small FIFO for a downstream consumer using a valid/ready handshake. It sits between the raw key inputs and the menu/game control FSMs, so no key press is lost while the consumer is busy. The press rule is the team's standard one: a press event is the rising edge of "exactly one key asserted".

## Interface
- `KEY_W`, default 8: number of key lines. Only 8 is supported.
- `CODE_W`, default 3: width of the encoded key index, log2(`KEY_W`).
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and at least 2.
- `clk` input 1: system clock. All state is rising-edge triggered.
- `rst` input 1: reset, asynchronous, active-low. It clears all state.
- `key` input `KEY_W`: raw key vector. Bit i high means key i is pressed. The input is already synchronous to `clk`.
- `evt_ready` input 1: the consumer accepts the head entry on a cycle where `evt_valid && evt_ready`.
- `clr_ovf` input 1: synchronous clear of `overflow`.
- `evt_valid` output 1: the FIFO is not empty.
- `evt_code` output `CODE_W`: index of the head key (bit position, 0..7). Reads 0 when the FIFO is empty.
- `count` output `CODE_W`: number of occupied entries, range 0..`DEPTH`.
- `overflow` output 1: sticky flag. Set when a press is dropped because the FIFO is full.

## Operation
- **Hit decode.** This stage is combinational. `hit` = `key` is exactly one-hot. `code` = index of the set bit. Zero keys or more than one key gives `hit` = 0.
- **Edge stage.** Registers `hit_q` ← `hit`, `code_q` ← `code`, and `hit_d` ← `hit_q`. `push` = `hit_q & ~hit_d`, so there is one push per press.
- **Key-to-key change.** A direct change from one one-hot value to another (e.g. 0x01→0x02 with no release) does not produce a new push. The keys must pass through a non-hit state first.
- **FIFO storage.** `DEPTH` × `CODE_W` entries, with pointers `wr_ptr`/`rd_ptr` of width log2(`DEPTH`) that wrap modulo `DEPTH`. A separate occupancy counter drives `count`.
- **Pop.** `pop` = `evt_valid & evt_ready`.
- **Push while not full.** Writes `code_q` at `wr_ptr`.
- **Push while full.**
  - Without a pop in the same cycle: the event is dropped and `overflow` is set to 1.
  - With a pop in the same cycle: both operations happen, `count` is unchanged, and `overflow` is not set.
- **Push while empty.** There is no bypass: the entry becomes visible on the next cycle.
- **Overflow clear.** `clr_ovf` clears `overflow`. If `clr_ovf` and a drop occur in the same cycle, the set wins.
- **Reset values.** `evt_valid`=0, `evt_code`=0, `count`=0, `overflow`=0. Pointers, `hit_q`, `hit_d` and `code_q` reset to 0. Memory contents are don't-care.
- **Reset mid-operation.** All queued events are discarded. If a key is still held when `rst` is released, it produces one event after reset. This is because `hit_d` resets to 0.

## Timing
- **Latency.** If `key` becomes one-hot before clock edge E, `hit_q`=1 after E, the push is written at E+1, and `evt_valid`/`evt_code` are valid after E+1. Total latency is 2 cycles.
- **Throughput.** At most one push per cycle (in practice far fewer) and at most one pop per cycle.
- **Output registration.** `evt_valid`, `count` and `overflow` are registered outputs. `evt_code` is read from the registered `rd_ptr` and is glitch-free at clock edges.
- **Consumer rule.** `evt_ready` may depend combinationally on `evt_valid`/`evt_code`. The block never combines `evt_ready` back into `evt_valid`.

## Structure
- **Shared package `key_pkg`.**
  - Constants `KEY_W`=8 and `CODE_W`=3.
  - Function `onehot_to_code`, returning the index and a valid bit.
  - Key index constants `KEY_0`..`KEY_7`, for reuse by the control FSMs.
- **Sub-module `key_press_detect`.** Contains the hit decode plus the edge stage. Outputs `push`/`code_q`.
- **Top module.** The FIFO logic, its counter and the overflow flag live in the top module.

## Test plan
1. Reset, then `key`=0x08 held for 10 cycles, then 0x00. Expected: exactly one entry, `evt_code`=3, `evt_valid` rises 2 cycles after the key changes, `count`=1.
2. `evt_ready`=0. Presses 0x01, 0x02, 0x04, 0x08, 0x10, each separated by 0x00. Expected: `count`=4, `overflow`=1. Popping then yields 0, 1, 2, 3 in order, and `evt_code`=0 when empty.
3. FIFO full with `evt_ready`=1, and a new press 0x80 pushed in the same cycle as a pop. Expected: `count` stays 4, `overflow` stays 0, and 7 appears last.
4. Invalid and held inputs: `key`=0x11 and `key`=0x00 produce no event. A direct change 0x40→0x20 produces only one event, with code 6.
5. `rst` asserted asynchronously while `count`=3 and 0x02 is held. Expected: outputs go to 0 immediately. After release, one event with code 1 appears 2 cycles later.
6. Drop and `clr_ovf` in the same cycle. Expected: `overflow`=1. A `clr_ovf` alone then gives 0.
